// File: rtl/result_uart_pkg.sv
// result_uart_pkg: shared FSM encoding and frame constants for result_uart_tx.
package result_uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    localparam int DATA_W = 8;
    localparam int FRAME_BITS = 10;
    localparam logic [DATA_W-1:0] ASCII_OFFSET = 8'h30;
    function automatic logic [DATA_W-1:0] to_ascii(input logic [2:0] v);
        return ASCII_OFFSET + {5'b0, v};
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with first-word-fall-through read.
// Ports: clk, rst (async active-low), push/din write side, pop/dout read side,
//        full, empty, count (occupancy, 0..DEPTH).
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [4:0]       count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [4:0] count_q, count_d;
    logic do_push, do_pop;
    assign full = count_q == 5'(DEPTH);
    assign empty = count_q == 5'd0;
    assign count = count_q;
    assign dout = mem_q[rd_ptr_q];
    assign do_pop = pop && !empty;
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign do_push = push && (!full || do_pop);
    // Pointers are AW bits wide and DEPTH is a power of two, so they wrap naturally.
    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d = count_q + 5'(do_push) - 5'(do_pop);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q <= count_d;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end
endmodule

// File: rtl/result_uart_tx.sv
// result_uart_tx: buffers ASCII-encoded 3-bit results and sends them as UART 8N1 frames.
// Ports: clk, rst (async active-low), capture/result push side,
//        tx serial line (idle high), busy (frame in progress),
//        fifo_count (buffered entries), overflow (sticky dropped-capture flag).
module result_uart_tx
    import result_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       capture,
    input  logic [2:0] result,
    output logic       tx,
    output logic       busy,
    output logic [4:0] fifo_count,
    output logic       overflow
);
    localparam logic [15:0] RELOAD = 16'(CLKS_PER_BIT - 1);
    state_t state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0] idx_q, idx_d;
    logic [DATA_W-1:0] shift_q, shift_d, head;
    logic tx_q, tx_d, busy_q, busy_d, ovf_q, ovf_d;
    logic full, empty, pop, bit_end;
    sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(capture),
        .din(to_ascii(result)),
        .pop(pop),
        .dout(head),
        .full(full),
        .empty(empty),
        .count(fifo_count)
    );
    assign bit_end = cnt_q == 16'd0;
    // Load a new byte either from idle or straight out of a finished stop bit.
    assign pop = !empty && (state_q == IDLE || (state_q == STOP && bit_end));
    assign tx = tx_q;
    assign busy = busy_q;
    assign overflow = ovf_q;
    always_comb begin
        state_d = state_q;
        idx_d = idx_q;
        shift_d = shift_q;
        tx_d = tx_q;
        case (state_q)
            IDLE: if (pop) begin
                state_d = START;
                shift_d = head;
                tx_d = 1'b0;
            end
            START: if (bit_end) begin
                state_d = DATA;
                tx_d = shift_q[0];
                shift_d = shift_q >> 1;
                idx_d = '0;
            end
            DATA: if (bit_end) begin
                state_d = idx_q == 3'(DATA_W - 1) ? STOP : DATA;
                tx_d = idx_q == 3'(DATA_W - 1) ? 1'b1 : shift_q[0];
                shift_d = shift_q >> 1;
                idx_d = idx_q + 1'b1;
            end
            STOP: if (bit_end) begin
                state_d = pop ? START : IDLE;
                tx_d = !pop;
                shift_d = pop ? head : shift_q;
            end
        endcase
        // Counter rests at 0 in IDLE so the first edge with data starts immediately.
        cnt_d = state_d == IDLE ? 16'd0 : bit_end ? RELOAD : cnt_q - 1'b1;
        busy_d = state_d != IDLE;
        ovf_d = ovf_q | (capture & full & !pop);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            idx_q <= '0;
            shift_q <= '0;
            tx_q <= 1'b1;
            busy_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            shift_q <= shift_d;
            tx_q <= tx_d;
            busy_q <= busy_d;
            ovf_q <= ovf_d;
        end
    end
endmodule

// File: tb/tb_result_uart_tx.sv
// tb_result_uart_tx: directed and random checks of result_uart_tx (4 clks/bit, 4-deep FIFO).
module tb_result_uart_tx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic capture = 1'b0;
    logic [2:0] result = 3'd0;
    logic tx, busy, overflow;
    logic [4:0] fifo_count;
    int checks = 0;
    int fails = 0;
    int n_rx = 0;
    bit mon_en = 1'b0;
    logic [7:0] exp_q[$];

    result_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
        .clk(clk),
        .rst(rst),
        .capture(capture),
        .result(result),
        .tx(tx),
        .busy(busy),
        .fifo_count(fifo_count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // Frame checker: called at the negedge that is cycle 'start' of a 40-cycle frame.
    task automatic expect_frame(input logic [7:0] b, input int start, input string name);
        logic [9:0] bits;
        bits = {1'b1, b, 1'b0};
        for (int k = start; k < 40; k++) begin
            checks++;
            if (tx !== bits[k/4] || busy !== 1'b1) begin
                fails++;
                $display("FAIL %s cycle%0d: tx=%b busy=%b expected tx=%b busy=1", name, k, tx, busy, bits[k/4]);
            end
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        capture = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 5'd0 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL reset_async: tx=%b busy=%b count=%0d ovf=%b expected 1 0 0 0", tx, busy, fifo_count, overflow);
        end
        capture = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 5'd0) begin
            fails++;
            $display("FAIL reset_held: tx=%b busy=%b count=%0d expected 1 0 0", tx, busy, fifo_count);
        end
        capture = 1'b0;
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        capture = 1'b1;
        result = 3'd5;
        @(negedge clk);
        capture = 1'b0;
        checks++;
        if (fifo_count !== 5'd1 || tx !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL single_push: count=%0d tx=%b busy=%b expected 1 1 0", fifo_count, tx, busy);
        end
        @(negedge clk);
        checks++;
        if (fifo_count !== 5'd0) begin
            fails++;
            $display("FAIL single_pop: count=%0d expected 0", fifo_count);
        end
        expect_frame(8'h35, 0, "single");
        checks++;
        if (busy !== 1'b0 || tx !== 1'b1 || fifo_count !== 5'd0) begin
            fails++;
            $display("FAIL single_end: busy=%b tx=%b count=%0d expected 0 1 0", busy, tx, fifo_count);
        end
    endtask

    task automatic test_burst();
        logic [2:0] vals [3] = '{3'd1, 3'd2, 3'd7};
        for (int i = 0; i < 3; i++) begin
            capture = 1'b1;
            result = vals[i];
            @(negedge clk);
        end
        capture = 1'b0;
        expect_frame(8'h31, 1, "burst0");
        expect_frame(8'h32, 0, "burst1");
        expect_frame(8'h37, 0, "burst2");
        checks++;
        if (busy !== 1'b0 || tx !== 1'b1) begin
            fails++;
            $display("FAIL burst_end: busy=%b tx=%b expected 0 1", busy, tx);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] bytes [4] = '{8'h31, 8'h32, 8'h33, 8'h34};
        for (int i = 0; i < 6; i++) begin
            capture = 1'b1;
            result = 3'(i);
            @(negedge clk);
        end
        capture = 1'b0;
        checks++;
        if (overflow !== 1'b1 || fifo_count !== 5'd4) begin
            fails++;
            $display("FAIL ovf_set: ovf=%b count=%0d expected 1 4", overflow, fifo_count);
        end
        expect_frame(8'h30, 4, "ovf0");
        for (int i = 0; i < 4; i++) expect_frame(bytes[i], 0, "ovf_n");
        checks++;
        if (busy !== 1'b0 || fifo_count !== 5'd0 || overflow !== 1'b1) begin
            fails++;
            $display("FAIL ovf_sticky: busy=%b count=%0d ovf=%b expected 0 0 1", busy, fifo_count, overflow);
        end
    endtask

    task automatic test_full_pop();
        logic [7:0] bytes [5] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h36};
        do_reset();
        checks++;
        if (overflow !== 1'b0) begin
            fails++;
            $display("FAIL ovf_clear: ovf=%b expected 0", overflow);
        end
        for (int i = 0; i < 5; i++) begin
            capture = 1'b1;
            result = 3'(i);
            @(negedge clk);
        end
        capture = 1'b0;
        checks++;
        if (fifo_count !== 5'd4 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL fullpop_fill: count=%0d ovf=%b expected 4 0", fifo_count, overflow);
        end
        repeat (36) @(negedge clk);
        checks++;
        if (tx !== 1'b1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL fullpop_stop: tx=%b busy=%b expected 1 1", tx, busy);
        end
        capture = 1'b1;
        result = 3'd6;
        @(negedge clk);
        capture = 1'b0;
        checks++;
        if (fifo_count !== 5'd4 || overflow !== 1'b0 || tx !== 1'b0) begin
            fails++;
            $display("FAIL fullpop_same_edge: count=%0d ovf=%b tx=%b expected 4 0 0", fifo_count, overflow, tx);
        end
        for (int i = 0; i < 5; i++) expect_frame(bytes[i], 0, "fullpop");
        checks++;
        if (busy !== 1'b0 || fifo_count !== 5'd0 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL fullpop_end: busy=%b count=%0d ovf=%b expected 0 0 0", busy, fifo_count, overflow);
        end
    endtask

    task automatic test_reset_mid();
        capture = 1'b1;
        result = 3'd2;
        @(negedge clk);
        result = 3'd3;
        @(negedge clk);
        capture = 1'b0;
        repeat (17) @(negedge clk);
        checks++;
        if (tx !== 1'b0 || busy !== 1'b1 || fifo_count !== 5'd1) begin
            fails++;
            $display("FAIL mid_pre: tx=%b busy=%b count=%0d expected 0 1 1", tx, busy, fifo_count);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 5'd0) begin
            fails++;
            $display("FAIL mid_abort: tx=%b busy=%b count=%0d expected 1 0 0", tx, busy, fifo_count);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        capture = 1'b1;
        result = 3'd0;
        @(negedge clk);
        capture = 1'b0;
        checks++;
        if (fifo_count !== 5'd1 || tx !== 1'b1) begin
            fails++;
            $display("FAIL mid_repush: count=%0d tx=%b expected 1 1", fifo_count, tx);
        end
        @(negedge clk);
        expect_frame(8'h30, 0, "mid_frame");
        checks++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL mid_end: busy=%b expected 0", busy);
        end
    endtask

    // UART receiver: centres on each bit and compares against the queue of pushed bytes.
    initial begin : monitor
        logic [7:0] d;
        logic st, sp;
        logic [7:0] want;
        forever begin
            @(negedge clk);
            if (mon_en && tx === 1'b0) begin
                repeat (2) @(negedge clk);
                st = tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (4) @(negedge clk);
                    d[i] = tx;
                end
                repeat (4) @(negedge clk);
                sp = tx;
                checks++;
                n_rx++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL rand_unexpected: got byte %h with empty model queue", d);
                end else begin
                    want = exp_q.pop_front();
                    if (d !== want || st !== 1'b0 || sp !== 1'b1) begin
                        fails++;
                        $display("FAIL rand_byte: got %h start=%b stop=%b expected %h start=0 stop=1", d, st, sp, want);
                    end
                end
            end
        end
    end

    task automatic test_random();
        int r;
        do_reset();
        exp_q.delete();
        n_rx = 0;
        mon_en = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            if (exp_q.size() < 4 && $urandom_range(0, 19) == 0) begin
                r = int'($urandom_range(0, 7));
                result = 3'(r);
                capture = 1'b1;
                exp_q.push_back(8'(8'h30 + r));
            end else begin
                capture = 1'b0;
                result = 3'($urandom_range(0, 7));
            end
            @(negedge clk);
        end
        capture = 1'b0;
        for (int c = 0; c < 2000 && exp_q.size() != 0; c++) @(negedge clk);
        repeat (4) @(negedge clk);
        mon_en = 1'b0;
        checks++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL rand_drain: %0d bytes unreceived busy=%b expected 0 0", exp_q.size(), busy);
        end
        checks++;
        if (n_rx < 10 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL rand_volume: received=%0d ovf=%b expected >=10 0", n_rx, overflow);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/result_uart_tx.md
RESULT_UART_TX -- requirements
Module: result_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clk cycles per UART bit period; legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 4: capture buffer entries; power of two, 2..16.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 capture  input  1  sample-request strobe, one push per high cycle.
REQ-006 result  input  3  value from the dice/traffic-light selector output.
REQ-007 tx  output  1  UART 8N1 serial line, idle high.
REQ-008 busy  output  1  high while a frame is in progress (START, DATA or STOP state).
REQ-009 fifo_count  output  5  number of entries currently buffered.
REQ-010 overflow  output  1  sticky flag, set when a capture is dropped.

Function
REQ-011 A capture high at a rising edge with FIFO not full SHALL push byte 8'h30 + result (ASCII '0'..'7').
REQ-012 A capture with FIFO full and no pop in that cycle SHALL be dropped and SHALL set overflow.
REQ-013 Push and pop in the same cycle SHALL both take effect, with fifo_count unchanged and no overflow, even when full.
REQ-014 The FSM states SHALL be IDLE, START, DATA and STOP.
REQ-015 IDLE -> START SHALL occur at the first edge where the FIFO is non-empty, popping the head byte into a shift register in that same edge.
REQ-016 Given REQ-015, a capture into an empty FIFO in IDLE at edge N SHALL drive tx low from edge N+1.
REQ-017 Each state SHALL hold for exactly CLKS_PER_BIT cycles per bit, timed by a bit-period counter that reloads on every bit boundary.
REQ-018 START SHALL drive tx=0 for one bit period.
REQ-019 DATA SHALL send 8 bits LSB first, with a 3-bit index wrapping 7->0 on exit to STOP.
REQ-020 STOP SHALL drive tx=1 for one bit period.
REQ-021 At the end of STOP the FSM SHALL enter START directly (back-to-back frames, no idle gap) if the FIFO is non-empty, else IDLE.
REQ-022 A full frame SHALL last exactly 10*CLKS_PER_BIT cycles.
REQ-023 tx SHALL be driven from a register only (glitch-free), and result SHALL be sampled only on the push edge.
REQ-024 capture held high for K cycles SHALL be treated as K pushes, with no edge detection.
REQ-025 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-026 fifo_count SHALL saturate at neither bound: it never exceeds FIFO_DEPTH and never goes below 0.

Reset
REQ-027 While rst=0 the block SHALL hold tx=1, busy=0, fifo_count=0, overflow=0, FSM=IDLE, pointers=0 and counters=0, independent of clk.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately (tx returns high asynchronously) and SHALL discard buffered entries.
REQ-029 overflow SHALL clear only on reset.
REQ-030 After reset deasserts, the first capture SHALL behave per REQ-016.

Structure
REQ-031 The FSM state encoding, the ASCII offset 8'h30, the frame length of 10 bits and the data width of 8 SHALL reside in shared package result_uart_pkg.
REQ-032 The buffer SHALL be a sub-module named sync_fifo, parameterised on width and depth, exposing push, pop, full, empty and count.
REQ-033 The FSM, bit-period counter and shift register SHALL reside in result_uart_tx itself.

Verification (bench uses CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-034 Single capture: rst released, capture one cycle with result=3'd5 -> tx low at next edge, bits LSB first 1,0,1,0,1,1,0,0 (8'h35), stop=1; busy high 40 cycles; fifo_count returns to 0.
REQ-035 Burst: captures on 3 consecutive cycles with result=1,2,7 -> frames 8'h31, 8'h32, 8'h37 back-to-back, total 120 cycles of busy, no idle bit between frames.
REQ-036 Overflow: 6 consecutive captures during IDLE -> the 1st pops immediately, the next 4 fill the FIFO, the 6th is dropped; overflow=1 and stays 1 after all 5 frames are sent.
REQ-037 Full with simultaneous pop: FIFO at 4 entries, capture on the exact edge STOP ends -> fifo_count stays 4 and overflow stays 0.
REQ-038 Reset mid-frame: rst=0 during DATA bit 3 -> tx=1, busy=0, fifo_count=0 asynchronously; after release, capture with result=0 -> clean frame 8'h30.
REQ-039 Scoreboard: a UART monitor decodes tx and compares every received byte against a model queue of pushed bytes for a 1000-cycle random capture/result run.
